// File: rtl/result_checker_pkg.sv
// Shared types and constants for the result checker slice.
//   state_e                : checker FSM state encoding (IDLE=0, SETTLE=1, DONE=2)
//   DEFAULT_STABLE_CYCLES  : default settle requirement
//   DEFAULT_TIMEOUT_CYCLES : default settle window
//   CNT_W                  : width of the internal settle/timeout counters
package result_check_pkg;

  localparam int unsigned DEFAULT_STABLE_CYCLES  = 4;
  localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 64;
  localparam int unsigned CNT_W                  = 16;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_DONE   = 2'd2
  } state_e;

endpackage

// File: rtl/result_checker_if.sv
// Bundle between a unit-test bench (master) and the result checker (slave).
//   start/expected/result     : master -> checker (arm pulse, golden word, word under test)
//   busy/done/pass/fail/
//   timed_out/observed/
//   change_count              : checker -> master (status, verdict, diagnostics)
interface result_checker_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic [WIDTH-1:0] expected;
  logic [WIDTH-1:0] result;
  logic             busy;
  logic             done;
  logic             pass;
  logic             fail;
  logic             timed_out;
  logic [WIDTH-1:0] observed;
  logic [7:0]       change_count;

  modport master (
    output start, expected, result,
    input  busy, done, pass, fail, timed_out, observed, change_count
  );

  modport slave (
    input  start, expected, result,
    output busy, done, pass, fail, timed_out, observed, change_count
  );
endinterface

// File: rtl/result_checker_stable_detector.sv
// Tracks the word under test while the checker is settling.
//   clk, reset   : clock, async active-low reset
//   clear        : load observed from result and zero the counters
//   enable       : sample result this cycle (update observed/counters)
//   result       : word under test
//   observed     : last sampled word
//   change_count : saturating count of changes seen since clear
//   stable       : result matches observed and has done so for STABLE_CYCLES-1 samples
module stable_detector
  import result_check_pkg::*;
#(
  parameter int unsigned WIDTH         = 32,
  parameter int unsigned STABLE_CYCLES = DEFAULT_STABLE_CYCLES
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             enable,
  input  logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] observed,
  output logic [7:0]       change_count,
  output logic             stable
);

  logic [WIDTH-1:0] observed_q, observed_d;
  logic [CNT_W-1:0] stable_cnt_q, stable_cnt_d;
  logic [7:0]       change_cnt_q, change_cnt_d;
  logic             same;

  assign same = (result == observed_q);

  always_comb begin
    observed_d   = observed_q;
    stable_cnt_d = stable_cnt_q;
    change_cnt_d = change_cnt_q;
    if (clear) begin
      observed_d   = result;
      stable_cnt_d = '0;
      change_cnt_d = '0;
    end else if (enable) begin
      if (!same) begin
        observed_d   = result;
        stable_cnt_d = '0;
        if (change_cnt_q != '1) change_cnt_d = change_cnt_q + 8'd1;
      end else begin
        stable_cnt_d = stable_cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      observed_q   <= '0;
      stable_cnt_q <= '0;
      change_cnt_q <= '0;
    end else begin
      observed_q   <= observed_d;
      stable_cnt_q <= stable_cnt_d;
      change_cnt_q <= change_cnt_d;
    end
  end

  assign stable       = same && (stable_cnt_q == CNT_W'(STABLE_CYCLES - 1));
  assign observed     = observed_q;
  assign change_count = change_cnt_q;

endmodule

// File: rtl/result_checker.sv
// Waits for a result word to settle after an arm pulse, then compares it
// against a latched expected value and reports pass/fail/timeout.
//   clk   : system clock, rising edge
//   reset : asynchronous, active-low reset
//   chk   : slave side of result_checker_if (start/expected/result in,
//           busy/done/pass/fail/timed_out/observed/change_count out)
module result_checker
  import result_check_pkg::*;
#(
  parameter int unsigned WIDTH          = 32,
  parameter int unsigned STABLE_CYCLES  = DEFAULT_STABLE_CYCLES,
  parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input logic             clk,
  input logic             reset,
  result_checker_if.slave chk
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] exp_q, exp_d;
  logic [CNT_W-1:0] timeout_q, timeout_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;
  logic             fail_q, fail_d;
  logic             to_q, to_d;

  logic             det_clear, det_enable, det_stable;
  logic             timeout_hit;

  assign timeout_hit = (timeout_q == CNT_W'(TIMEOUT_CYCLES - 1));

  stable_detector #(
    .WIDTH         (WIDTH),
    .STABLE_CYCLES (STABLE_CYCLES)
  ) u_det (
    .clk          (clk),
    .reset        (reset),
    .clear        (det_clear),
    .enable       (det_enable),
    .result       (chk.result),
    .observed     (chk.observed),
    .change_count (chk.change_count),
    .stable       (det_stable)
  );

  always_comb begin
    state_d    = state_q;
    exp_d      = exp_q;
    timeout_d  = timeout_q;
    busy_d     = busy_q;
    done_d     = done_q;
    pass_d     = pass_q;
    fail_d     = fail_q;
    to_d       = to_q;
    det_clear  = 1'b0;
    det_enable = 1'b0;
    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (chk.start) begin
          state_d   = ST_SETTLE;
          exp_d     = chk.expected;
          timeout_d = '0;
          busy_d    = 1'b1;
          done_d    = 1'b0;
          pass_d    = 1'b0;
          fail_d    = 1'b0;
          to_d      = 1'b0;
          det_clear = 1'b1;
        end
      end
      ST_SETTLE: begin
        timeout_d  = timeout_q + CNT_W'(1);
        // The timeout edge is the last SETTLE cycle: the word is not resampled
        // there, so change_count/observed reflect the window's first
        // TIMEOUT_CYCLES-1 samples. On a stable exit result==observed anyway.
        det_enable = !timeout_hit;
        if (det_stable) begin
          state_d = ST_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = (chk.observed == exp_q);
          fail_d  = (chk.observed != exp_q);
          to_d    = 1'b0;
        end else if (timeout_hit) begin
          state_d = ST_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = 1'b0;
          fail_d  = 1'b1;
          to_d    = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      exp_q     <= '0;
      timeout_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
      fail_q    <= 1'b0;
      to_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      exp_q     <= exp_d;
      timeout_q <= timeout_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      pass_q    <= pass_d;
      fail_q    <= fail_d;
      to_q      <= to_d;
    end
  end

  assign chk.busy      = busy_q;
  assign chk.done      = done_q;
  assign chk.pass      = pass_q;
  assign chk.fail      = fail_q;
  assign chk.timed_out = to_q;

endmodule

// File: tb/tb_result_checker.sv
// Scoreboard bench for result_checker: stimulus pushes expected verdicts,
// a negedge monitor pops and compares on every rising done.
module tb_result_checker;

  typedef struct {
    int          cyc;
    logic        pass;
    logic        fail;
    logic        to;
    logic [31:0] obs;
    logic [7:0]  cc;
  } txn_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   passed = 0;
  int   total = 0;

  txn_t q0[$];
  txn_t q1[$];
  logic prev0 = 1'b0;
  logic prev1 = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  result_checker_if #(.WIDTH(32)) if0 ();
  result_checker_if #(.WIDTH(32)) if1 ();

  result_checker #(.WIDTH(32)) dut0 (
    .clk   (clk),
    .reset (rst_n),
    .chk   (if0)
  );

  result_checker #(.WIDTH(32), .STABLE_CYCLES(64), .TIMEOUT_CYCLES(64)) dut1 (
    .clk   (clk),
    .reset (rst_n),
    .chk   (if1)
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got 0x%0h required 0x%0h (cycle %0d)", name, got, exp, cyc);
  endtask

  task automatic compare(input string tag, input txn_t e, input txn_t g);
    chk({tag, " done_cycle"}, 32'(g.cyc), 32'(e.cyc));
    chk({tag, " pass"}, {31'b0, g.pass}, {31'b0, e.pass});
    chk({tag, " fail"}, {31'b0, g.fail}, {31'b0, e.fail});
    chk({tag, " timed_out"}, {31'b0, g.to}, {31'b0, e.to});
    chk({tag, " observed"}, g.obs, e.obs);
    chk({tag, " change_count"}, {24'b0, g.cc}, {24'b0, e.cc});
  endtask

  // Monitor: compares each completed check against the scoreboard.
  always @(negedge clk) begin
    txn_t g;
    txn_t e;
    if (if0.done && !prev0) begin
      g = '{cyc, if0.pass, if0.fail, if0.timed_out, if0.observed, if0.change_count};
      if (q0.size() == 0) chk("dut0 unexpected done", 32'd1, 32'd0);
      else begin
        e = q0.pop_front();
        compare("dut0", e, g);
      end
    end
    if (if1.done && !prev1) begin
      g = '{cyc, if1.pass, if1.fail, if1.timed_out, if1.observed, if1.change_count};
      if (q1.size() == 0) chk("dut1 unexpected done", 32'd1, 32'd0);
      else begin
        e = q1.pop_front();
        compare("dut1", e, g);
      end
    end
    prev0 <= if0.done;
    prev1 <= if1.done;
  end

  // Arms dut0 at this negedge; returns the edge number that samples start.
  task automatic arm0(input logic [31:0] expv, input logic [31:0] res, output int se);
    if0.start    = 1'b1;
    if0.expected = expv;
    if0.result   = res;
    se = cyc + 1;
  endtask

  task automatic wait_done0(input string name, input int max);
    int n = 0;
    while (!if0.done && n < max) begin
      @(negedge clk);
      n++;
    end
    if (!if0.done) chk({name, " done timeout"}, 32'd0, 32'd1);
  endtask

  initial begin
    int se;
    if0.start = 1'b0; if0.expected = '0; if0.result = '0;
    if1.start = 1'b0; if1.expected = '0; if1.result = '0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst busy", {31'b0, if0.busy}, 32'd0);
    chk("rst done", {31'b0, if0.done}, 32'd0);
    chk("rst pass", {31'b0, if0.pass}, 32'd0);
    chk("rst fail", {31'b0, if0.fail}, 32'd0);
    chk("rst timed_out", {31'b0, if0.timed_out}, 32'd0);
    chk("rst observed", if0.observed, 32'd0);
    chk("rst change_count", {24'b0, if0.change_count}, 32'd0);
    chk("rst dut1 done", {31'b0, if1.done}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // STABLE=TIMEOUT=64 with constant result: stable exit wins
    if1.start = 1'b1; if1.expected = 32'h5; if1.result = 32'h5;
    q1.push_back('{cyc + 1 + 64, 1'b1, 1'b0, 1'b0, 32'h5, 8'd0});
    @(negedge clk);
    if1.start = 1'b0;
    for (int i = 0; i < 100 && !if1.done; i++) @(negedge clk);
    if (!if1.done) chk("dut1 coincide done timeout", 32'd0, 32'd1);
    @(negedge clk);

    // Result 0 for one cycle then 2: pass after one change
    arm0(32'h2, 32'h0, se);
    q0.push_back('{se + 5, 1'b1, 1'b0, 1'b0, 32'h2, 8'd1});
    @(negedge clk);
    if0.start = 1'b0; if0.result = 32'h2;
    wait_done0("t1", 20);
    @(negedge clk);

    // Constant mismatch from DONE: fail, no timeout
    arm0(32'h1, 32'h2, se);
    q0.push_back('{se + 4, 1'b0, 1'b1, 1'b0, 32'h2, 8'd0});
    @(negedge clk);
    if0.start = 1'b0;
    wait_done0("t2", 20);
    @(negedge clk);

    // Toggling result never settles: timeout
    arm0(32'h5, 32'h0, se);
    q0.push_back('{se + 64, 1'b0, 1'b1, 1'b1, 32'h1, 8'd63});
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if0.start = 1'b0;
      if (if0.done) break;
      if0.result = if0.result ^ 32'h1;
    end
    if (!if0.done) chk("t3 done timeout", 32'd0, 32'd1);
    @(negedge clk);

    // Start repulsed in SETTLE is ignored
    arm0(32'h7, 32'h3, se);
    q0.push_back('{se + 5, 1'b0, 1'b1, 1'b0, 32'h4, 8'd1});
    @(negedge clk);
    if0.start = 1'b0; if0.result = 32'h4;
    @(negedge clk);
    if0.start = 1'b1; if0.expected = 32'h9;
    @(negedge clk);
    if0.start = 1'b0;
    wait_done0("t4", 20);
    @(negedge clk);

    // Start in DONE clears flags next cycle
    arm0(32'h4, 32'h4, se);
    q0.push_back('{se + 4, 1'b1, 1'b0, 1'b0, 32'h4, 8'd0});
    @(negedge clk);
    if0.start = 1'b0;
    chk("rearm done", {31'b0, if0.done}, 32'd0);
    chk("rearm pass", {31'b0, if0.pass}, 32'd0);
    chk("rearm fail", {31'b0, if0.fail}, 32'd0);
    chk("rearm busy", {31'b0, if0.busy}, 32'd1);
    wait_done0("t5", 20);
    @(negedge clk);

    // Asynchronous reset mid-SETTLE
    arm0(32'h1, 32'h0, se);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if0.start = 1'b0;
      if0.result = if0.result ^ 32'h1;
    end
    chk("pre-reset busy", {31'b0, if0.busy}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid rst busy", {31'b0, if0.busy}, 32'd0);
    chk("mid rst done", {31'b0, if0.done}, 32'd0);
    chk("mid rst fail", {31'b0, if0.fail}, 32'd0);
    chk("mid rst timed_out", {31'b0, if0.timed_out}, 32'd0);
    chk("mid rst observed", if0.observed, 32'd0);
    chk("mid rst change_count", {24'b0, if0.change_count}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Re-arm after reset
    arm0(32'hDEADBEEF, 32'hDEADBEEF, se);
    q0.push_back('{se + 4, 1'b1, 1'b0, 1'b0, 32'hDEADBEEF, 8'd0});
    @(negedge clk);
    if0.start = 1'b0;
    wait_done0("t6", 20);
    repeat (2) @(negedge clk);

    chk("scoreboard0 drained", 32'(q0.size()), 32'd0);
    chk("scoreboard1 drained", 32'(q1.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/result_checker.md
Name: result_checker

Overview:
- Downstream consumer of a generated FSM test module's 32-bit result output (e.g. out1).
- When armed, it waits for the result word to hold steady for a programmable number of cycles, then compares it against an expected value.
- Reports pass/fail/timeout so unit-test benches self-check instead of relying on $monitor output.
- Purely synchronous to clk; no combinational path from result to any output.

Parameters:
- WIDTH, 32, result/expected word width.
- STABLE_CYCLES, 4, consecutive unchanged cycles required before compare; legal range 1..TIMEOUT_CYCLES.
- TIMEOUT_CYCLES, 64, maximum cycles spent settling before forced timeout; must be < 2^16.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  single-cycle arm pulse.
- expected  input  WIDTH  expected result, latched on an accepted start.
- result  input  WIDTH  word under test, registered from the upstream FSM.
- busy  output  1  high while in SETTLE.
- done  output  1  high in DONE, held until the next accepted start.
- pass  output  1  valid while done; final word == expected.
- fail  output  1  valid while done; mismatch or timeout.
- timed_out  output  1  valid while done; settle window expired.
- observed  output  WIDTH  last sampled result word.
- change_count  output  8  number of result changes seen during SETTLE; saturates at 255.

Behaviour:
- Reset (reset=0, asynchronous):
  - State goes to IDLE.
  - All outputs 0, including observed and change_count.
  - Internal counters and the latched expected value cleared.
  - Applies immediately, even mid-SETTLE.
- States: IDLE, SETTLE, DONE (2-bit encoding).
- IDLE or DONE with start=1 (accepted start):
  - exp_q <= expected; observed <= result.
  - stable_cnt <= 0; timeout_cnt <= 0; change_count <= 0.
  - done, pass, fail, timed_out <= 0; state -> SETTLE.
- SETTLE, every cycle:
  - timeout_cnt increments.
  - start is ignored.
  - If result != observed: observed <= result, stable_cnt <= 0, change_count increments with saturation.
  - Else: stable_cnt increments.
- Stable exit:
  - Condition: result == observed and stable_cnt == STABLE_CYCLES-1.
  - Action: state -> DONE, done <= 1, pass <= (observed == exp_q), fail <= !pass, timed_out <= 0.
- Timeout exit:
  - Condition: timeout_cnt == TIMEOUT_CYCLES-1 and the stable exit condition is false.
  - Action: state -> DONE, done <= 1, fail <= 1, pass <= 0, timed_out <= 1.
- Simultaneous stable and timeout conditions: the stable exit wins.
- Latency:
  - For a constant result, done rises exactly STABLE_CYCLES cycles after the start edge.
  - A never-settling result gives done exactly TIMEOUT_CYCLES cycles after the start edge.
- DONE: all outputs held; observed frozen (result not sampled).
- busy = (state == SETTLE), registered alongside the state.
- Compare is a full-width unsigned equality; no arithmetic on result.

Decomposition:
- Shared package result_check_pkg holds:
  - State typedef and encodings: IDLE=0, SETTLE=1, DONE=2.
  - Default STABLE_CYCLES/TIMEOUT_CYCLES constants.
  - Counter width constant (16).
- One natural sub-module, stable_detector:
  - Owns the observed register, stable_cnt and the change_count saturation.
  - Exposes a stable pulse and a clear input.
- result_checker owns the FSM, timeout counter and verdict flags.

Test Plan:
- expected=2; result held 0 for 1 cycle after start, then 2 forever -> done at start+1+STABLE_CYCLES (cycle 5), pass=1, fail=0, change_count=1, observed=32'h2.
- expected=1; result constant 2 -> done at start+4, pass=0, fail=1, timed_out=0, change_count=0.
- result toggles 0/1 every cycle -> done at start+64, timed_out=1, fail=1, change_count=63.
- STABLE_CYCLES=64, TIMEOUT_CYCLES=64, constant result -> stable and timeout coincide; pass=1, timed_out=0.
- reset=0 asserted mid-SETTLE (cycle 10) -> all outputs 0 immediately, busy=0; start after release re-arms normally.
- start pulsed again in SETTLE -> ignored (change_count not cleared); start in DONE -> flags clear next cycle, busy=1.
